// File: rtl/spi_target_io.sv
// SPI target (mode 0, MSB first, 8-bit frames) exposed as two J1 IO registers.
// SPI pins are resynchronised; the host must keep sck at or below clk/8.
module spi_target_io #(
   parameter logic [15:0] ADDR_DATA = 16'd120,
   parameter logic [15:0] ADDR_STAT = 16'd121,
   parameter logic [7:0]  FILL      = 8'hFF
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic        io_rd,
   input  logic        io_wr,
   input  logic [15:0] mem_addr,
   input  logic [15:0] dout,
   output logic [15:0] io_din,
   input  logic        sck,
   input  logic        cs_n,
   input  logic        mosi,
   output logic        miso,
   output logic        miso_oe,
   output logic        rx_irq
);

   typedef enum logic {
      IDLE,
      ACTIVE
   } state_t;

   state_t     state_q;
   logic [2:0] sck_sync_q;
   logic [2:0] cs_sync_q;
   logic [1:0] mosi_sync_q;
   logic [2:0] bit_cnt_q;
   logic [7:0] rx_shift_q;
   logic [7:0] tx_shift_q;
   logic [7:0] rx_data_q;
   logic [7:0] tx_hold_q;
   logic       rx_valid_q;
   logic       overrun_q;
   logic       underrun_q;
   logic       tx_pending_q;
   logic       miso_q;
   logic       miso_oe_q;

   logic       sck_rise;
   logic       sck_fall;
   logic       cs_fall;
   logic       cs_rise;
   logic       sel_data;
   logic       sel_stat;
   logic       rd_data;
   logic       wr_data;
   logic       wr_stat;
   logic       active;
   logic       byte_done;
   logic       load_tx;
   logic [7:0] rx_byte_d;
   logic [7:0] tx_load_d;
   logic       unused_dout;

   // Bit [1] is the synchronised level, bit [2] the edge-detect history.
   assign sck_rise  = sck_sync_q[1] & ~sck_sync_q[2];
   assign sck_fall  = ~sck_sync_q[1] & sck_sync_q[2];
   assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
   assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];

   assign sel_data  = (mem_addr == ADDR_DATA);
   assign sel_stat  = (mem_addr == ADDR_STAT);
   assign rd_data   = io_rd & sel_data;
   assign wr_data   = io_wr & sel_data;
   assign wr_stat   = io_wr & sel_stat;

   assign active    = (state_q == ACTIVE);
   assign byte_done = active & ~cs_rise & sck_rise
                    & (bit_cnt_q == 3'd7);
   assign load_tx   = (~active & cs_fall) | byte_done;

   assign rx_byte_d = {rx_shift_q[6:0], mosi_sync_q[1]};
   assign tx_load_d = tx_pending_q ? tx_hold_q : FILL;

   assign unused_dout = ^dout[15:8];

   always_comb begin
      io_din = 16'd0;
      if (sel_data) begin
         io_din = {8'd0, rx_data_q};
      end else if (sel_stat) begin
         io_din = {11'd0, active, underrun_q, overrun_q,
                   ~tx_pending_q, rx_valid_q};
      end
   end

   assign miso    = miso_q;
   assign miso_oe = miso_oe_q;
   assign rx_irq  = rx_valid_q;

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         state_q      <= IDLE;
         sck_sync_q   <= 3'b000;
         cs_sync_q    <= 3'b111;
         mosi_sync_q  <= 2'b00;
         bit_cnt_q    <= 3'd0;
         rx_shift_q   <= 8'd0;
         tx_shift_q   <= 8'd0;
         rx_data_q    <= 8'd0;
         tx_hold_q    <= 8'd0;
         rx_valid_q   <= 1'b0;
         overrun_q    <= 1'b0;
         underrun_q   <= 1'b0;
         tx_pending_q <= 1'b0;
         miso_q       <= 1'b0;
         miso_oe_q    <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[1:0], sck};
         cs_sync_q   <= {cs_sync_q[1:0], cs_n};
         mosi_sync_q <= {mosi_sync_q[0], mosi};

         unique case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  state_q    <= ACTIVE;
                  bit_cnt_q  <= 3'd0;
                  miso_oe_q  <= 1'b1;
                  tx_shift_q <= tx_load_d;
                  miso_q     <= tx_load_d[7];
               end
            end
            ACTIVE: begin
               if (cs_rise) begin
                  state_q   <= IDLE;
                  bit_cnt_q <= 3'd0;
                  miso_oe_q <= 1'b0;
                  miso_q    <= 1'b0;
               end else if (sck_rise) begin
                  rx_shift_q <= rx_byte_d;
                  bit_cnt_q  <= bit_cnt_q + 3'd1;
                  if (byte_done) begin
                     tx_shift_q <= tx_load_d;
                     miso_q     <= tx_load_d[7];
                  end
               end else if (sck_fall && bit_cnt_q != 3'd0) begin
                  tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                  miso_q     <= tx_shift_q[6];
               end
            end
            default: state_q <= IDLE;
         endcase

         if (rd_data) begin
            rx_valid_q <= 1'b0;
         end
         if (byte_done) begin
            rx_data_q  <= rx_byte_d;
            rx_valid_q <= 1'b1;
         end

         // Clears are applied first so a same-cycle set wins.
         if (wr_stat && dout[2]) begin
            overrun_q <= 1'b0;
         end
         if (byte_done && rx_valid_q && !rd_data) begin
            overrun_q <= 1'b1;
         end
         if (wr_stat && dout[3]) begin
            underrun_q <= 1'b0;
         end
         if (load_tx && !tx_pending_q) begin
            underrun_q <= 1'b1;
         end

         if (load_tx) begin
            tx_pending_q <= 1'b0;
         end
         if (wr_data) begin
            tx_hold_q    <= dout[7:0];
            tx_pending_q <= 1'b1;
         end
      end
   end

endmodule
